// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART frame parser: SOF/LEN/payload/XOR-checksum, buffered stream out
module uart_frame_rx #(
  parameter int          MAX_LEN = 16,
  parameter int          TIMEOUT = 4096,
  parameter logic [7:0]  SOF     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  logic [2:0]    state;
  logic          pending;
  logic [7:0]    len;
  logic [7:0]    chk;
  logic [7:0]    idx;
  logic [7:0]    out_idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    buf_mem [0:(1<<IW)-1];

  logic fetch_state;
  logic timed_state;
  logic tmo_hit;

  assign fetch_state = (state != S_EMIT);
  assign timed_state = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign tmo_hit     = timed_state && !pending && (tcnt == TMO_LAST);

  // Data and last are gated by valid so they read 0 outside EMIT.
  assign m_data = m_valid ? buf_mem[out_idx[IW-1:0]] : 8'h00;
  assign m_last = m_valid && (out_idx == len - 8'd1);

  always_ff @(posedge clk) begin
    if (pending && state == S_PAYLOAD)
      buf_mem[idx[IW-1:0]] <= fifo_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HUNT;
      pending   <= 1'b0;
      fifo_rd   <= 1'b0;
      len       <= 8'h00;
      chk       <= 8'h00;
      idx       <= 8'h00;
      out_idx   <= 8'h00;
      tcnt      <= '0;
      m_valid   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      fifo_rd   <= 1'b0;
      // fifo_rd is registered, so pending covers the cycle the byte is on fifo_dout.
      pending   <= fifo_rd;
      if (fetch_state && !fifo_rd && !pending && !fifo_empty)
        fifo_rd <= 1'b1;

      if (pending || !timed_state)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);

      case (state)
        S_HUNT: begin
          if (pending && fifo_dout == SOF)
            state <= S_LEN;
        end
        S_LEN: begin
          if (pending) begin
            if (fifo_dout == 8'h00 || fifo_dout > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= S_HUNT;
            end else begin
              len   <= fifo_dout;
              chk   <= fifo_dout;
              idx   <= 8'h00;
              state <= S_PAYLOAD;
            end
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_HUNT;
          end
        end
        S_PAYLOAD: begin
          if (pending) begin
            chk <= chk ^ fifo_dout;
            idx <= idx + 8'd1;
            if (idx + 8'd1 == len)
              state <= S_CHK;
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_HUNT;
          end
        end
        S_CHK: begin
          if (pending) begin
            if (fifo_dout != chk) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= S_HUNT;
            end else begin
              frame_ok <= 1'b1;
              m_valid  <= 1'b1;
              out_idx  <= 8'h00;
              state    <= S_EMIT;
            end
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_HUNT;
          end
        end
        S_EMIT: begin
          if (m_valid && m_ready) begin
            if (out_idx == len - 8'd1) begin
              m_valid <= 1'b0;
              state   <= S_HUNT;
            end else begin
              out_idx <= out_idx + 8'd1;
            end
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Frame parser sitting directly downstream of the UART receive FIFO; pulls received bytes through the FIFO read port.
- Recovers frames of the form SOF(0xA5), LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
- Buffers the payload internally and releases it on a valid/ready stream only after the checksum passes.
- Flags bad frames with an error code; discards non-SOF bytes between frames.

Parameters:
- MAX_LEN, 16, maximum payload length accepted (1..255); sets the internal buffer depth.
- TIMEOUT, 4096, idle clock cycles allowed between bytes inside a frame before it is aborted.
- SOF, 8'hA5, start-of-frame byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fifo_empty  in  1  RX FIFO empty flag
- fifo_dout  in  8  RX FIFO read data; valid the cycle after fifo_rd
- fifo_rd  out  1  RX FIFO read enable, one-cycle pulse
- m_data  out  8  payload byte out
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data
- m_last  out  1  marks the final payload byte of a frame
- frame_ok  out  1  one-cycle pulse: checksum matched
- frame_err  out  1  one-cycle pulse: frame aborted
- err_code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout; holds last error

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous, active-high.
  - Reset forces state HUNT and clears the read-pending flag, counters and checksum.
  - All outputs reset to 0; err_code resets to 0.
- Byte fetch (states HUNT/LEN/PAYLOAD/CHK only):
  - If no read is pending and fifo_empty=0, assert fifo_rd for one cycle and set the pending flag.
  - On the next cycle, fifo_dout is the consumed byte; clear pending.
  - At most one outstanding read; at most one byte per 2 cycles.
  - Never fetch in EMIT.
- HUNT:
  - Consumed byte == SOF goes to LEN; any other byte is dropped silently.
  - No timeout runs in HUNT.
- LEN:
  - byte==0 or byte>MAX_LEN: frame_err pulse, err_code=1, go to HUNT.
  - Otherwise latch len, set chk=byte, idx=0, go to PAYLOAD.
- PAYLOAD:
  - buf[idx]=byte, chk^=byte, idx++.
  - When idx reaches len, go to CHK.
- CHK:
  - byte!=chk: frame_err pulse, err_code=2, go to HUNT.
  - byte==chk: frame_ok pulse in the same cycle the state becomes EMIT; out_idx=0.
- EMIT:
  - m_valid=1, m_data=buf[out_idx], m_last=(out_idx==len-1).
  - Advance only when m_valid&&m_ready; m_data and m_last stay stable while m_ready=0.
  - After the handshake on the last byte, deassert m_valid and go to HUNT the next cycle.
- Timeout (LEN/PAYLOAD/CHK):
  - A counter increments every cycle and clears on each consumed byte.
  - When it reaches TIMEOUT: frame_err pulse, err_code=3, go to HUNT.
  - If a pending byte arrives in the same cycle, the byte wins and no timeout fires.
  - An in-flight read is always completed; its byte is discarded when the state is HUNT.
- A SOF value appearing inside LEN/PAYLOAD/CHK is treated as data (no resync).
- frame_ok and frame_err never assert in the same cycle.
- Reset mid-frame: the partial frame is discarded and nothing is emitted; bytes still in the FIFO are untouched.

Test Plan:
- FIFO holds A5 03 11 22 33 03 -> frame_ok pulse once; m_data 11,22,33 with m_last on 33; err_code stays 0; exactly 6 fifo_rd pulses.
- FIFO holds 00 FF A5 01 7E 7F -> 00 and FF dropped; single output byte 7E with m_last=1; frame_ok pulse.
- A5 02 10 20 33 (expected chk 32) -> frame_err pulse, err_code=2, no m_valid; a following A5 01 55 54 is then emitted correctly.
- A5 00 and, separately, A5 11 (MAX_LEN=16) -> frame_err, err_code=1 each; back in HUNT and the next byte is fetched.
- A5 02 10, then FIFO stays empty -> frame_err with err_code=3 exactly TIMEOUT cycles after 10 was consumed; a late 20 xx is dropped until the next A5.
- Valid 4-byte frame with m_ready low for 20 cycles after m_valid rises -> m_data held at byte 0, no fifo_rd during EMIT. Separately, reset asserted after 2 payload bytes -> all outputs 0, next complete frame parsed normally.
